// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and requester ids for the register-file write-back scheduler.
package rf_sched_pkg;

  localparam int unsigned NREG  = 15;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    REQ_WB = 1'b0,
    REQ_MC = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2
  import rf_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_id_e rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    case (valid)
      2'b01:   grant[REQ_WB] = 1'b1;
      2'b10:   grant[REQ_MC] = 1'b1;
      2'b11:   grant[rr_ptr_q] = 1'b1;
      default: grant = '0;
    endcase
    // The winner yields priority to the other requester on the next tie.
    if (grant[REQ_WB]) begin
      rr_ptr_d = REQ_MC;
    end else if (grant[REQ_MC]) begin
      rr_ptr_d = REQ_WB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= REQ_WB;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between pipeline WB and the multi-cycle unit,
// and tracks outstanding writes per register for decode hazard detection.
module regfile_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned NREG  = rf_sched_pkg::NREG,
  parameter int unsigned DW    = rf_sched_pkg::DW,
  parameter int unsigned AW    = rf_sched_pkg::AW,
  parameter int unsigned CNT_W = rf_sched_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_dest,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_dest,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_dest,
  output logic            issue_stall,
  input  logic [AW-1:0]   src_1,
  input  logic [AW-1:0]   src_2,
  output logic            hazard,
  output logic            wb_en,
  output logic [AW-1:0]   wb_dest,
  output logic [DW-1:0]   wb_data,
  output logic [NREG-1:0] pend_mask,
  output logic            err_bad_dest
);

  localparam logic [AW:0]      NREG_W  = (AW+1)'(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic in_range(input logic [AW-1:0] idx);
    return {1'b0, idx} < NREG_W;
  endfunction

  logic [1:0]       grant;
  logic             acc_valid;
  logic             acc_ok;
  logic [AW-1:0]    acc_dest;
  logic [DW-1:0]    acc_data;
  logic             issue_ok;
  logic             issue_sat;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             wb_en_q, wb_en_d;
  logic [AW-1:0]    wb_dest_q, wb_dest_d;
  logic [DW-1:0]    wb_data_q, wb_data_d;
  logic             err_q, err_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[REQ_WB];
  assign req1_ready = grant[REQ_MC];

  always_comb begin
    acc_valid = |grant;
    acc_dest  = grant[REQ_MC] ? req1_dest : req0_dest;
    acc_data  = grant[REQ_MC] ? req1_data : req0_data;
    acc_ok    = in_range(acc_dest);
    issue_ok  = issue_en & in_range(issue_dest);
  end

  always_comb begin
    issue_sat = 1'b0;
    hazard    = 1'b0;
    pend_mask = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (issue_dest == AW'(i) && cnt_q[i] == CNT_MAX) begin
        issue_sat = 1'b1;
      end
      pend_mask[i] = (cnt_q[i] != '0);
      if ((src_1 == AW'(i) || src_2 == AW'(i)) && cnt_q[i] != '0) begin
        hazard = 1'b1;
      end
    end
    issue_stall = issue_en & issue_sat;
  end

  // Saturation stalls the reservation even when a retire to the same register
  // would have made room this cycle.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      logic inc, dec;
      inc = issue_ok & ~issue_sat & (issue_dest == AW'(i));
      dec = acc_valid & acc_ok & (acc_dest == AW'(i)) & (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    wb_en_d   = acc_valid & acc_ok;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    if (wb_en_d) begin
      wb_dest_d = acc_dest;
      wb_data_d = acc_data;
    end
    err_d = err_q
          | (acc_valid & ~acc_ok)
          | (issue_en & ~in_range(issue_dest));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      wb_en_q   <= wb_en_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign wb_en        = wb_en_q;
  assign wb_dest      = wb_dest_q;
  assign wb_data      = wb_data_q;
  assign err_bad_dest = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a negedge-write register file model.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [3:0]  req0_dest;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_dest;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        issue_stall;
  logic [3:0]  src_1;
  logic [3:0]  src_2;
  logic        hazard;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic [14:0] pend_mask;
  logic        err_bad_dest;

  logic [31:0] rf_model [16];
  int          n_cmp;
  int          n_bad;

  regfile_wb_scheduler #(
    .NREG  (15),
    .DW    (32),
    .AW    (4),
    .CNT_W (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_dest    (req0_dest),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_dest    (req1_dest),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .issue_en     (issue_en),
    .issue_dest   (issue_dest),
    .issue_stall  (issue_stall),
    .src_1        (src_1),
    .src_2        (src_2),
    .hazard       (hazard),
    .wb_en        (wb_en),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .pend_mask    (pend_mask),
    .err_bad_dest (err_bad_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_en === 1'b1) rf_model[wb_dest] = wb_data;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    issue_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_dest = '0; req0_data = '0;
    req1_valid = 1'b0; req1_dest = '0; req1_data = '0;
    issue_en = 1'b0; issue_dest = '0;
    src_1 = '0; src_2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_wb_en",   64'(wb_en), 64'(0));
    check_eq("rst_wb_dest", 64'(wb_dest), 64'(0));
    check_eq("rst_wb_data", 64'(wb_data), 64'(0));
    check_eq("rst_pend",    64'(pend_mask), 64'(0));
    check_eq("rst_err",     64'(err_bad_dest), 64'(0));
    check_eq("rst_hazard",  64'(hazard), 64'(0));

    // 1: single request, one-cycle write latency, RF captures on negedge
    @(negedge clk);
    req0_valid = 1'b1; req0_dest = 4'd3; req0_data = 32'hA5;
    #1;
    check_eq("t1_req0_ready", 64'(req0_ready), 64'(1));
    check_eq("t1_req1_ready", 64'(req1_ready), 64'(0));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check_eq("t1_wb_en",   64'(wb_en), 64'(1));
    check_eq("t1_wb_dest", 64'(wb_dest), 64'(3));
    check_eq("t1_wb_data", 64'(wb_data), 64'(32'hA5));
    @(negedge clk); #1;
    check_eq("t1_rf3", 64'(rf_model[3]), 64'(32'hA5));
    @(posedge clk); #1;
    check_eq("t1_wb_en_idle", 64'(wb_en), 64'(0));

    // 2: contention alternates starting from req0 after reset
    apply_reset();
    req0_valid = 1'b1; req0_dest = 4'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_dest = 4'd2; req1_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      check_eq($sformatf("t2_req0_ready%0d", k), 64'(req0_ready), 64'((k % 2) == 0));
      check_eq($sformatf("t2_req1_ready%0d", k), 64'(req1_ready), 64'((k % 2) == 1));
      @(posedge clk); #1;
      check_eq($sformatf("t2_wb_dest%0d", k), 64'(wb_dest), (k % 2) == 0 ? 64'(1) : 64'(2));
      check_eq($sformatf("t2_wb_data%0d", k), 64'(wb_data), (k % 2) == 0 ? 64'(32'h11) : 64'(32'h22));
    end
    idle_inputs();

    // 3: saturation stall, hazard visibility, retire to zero
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      issue_en = 1'b1; issue_dest = 4'd5;
      #1;
      check_eq($sformatf("t3_stall%0d", k), 64'(issue_stall), 64'(0));
    end
    @(negedge clk); #1;
    check_eq("t3_stall_sat", 64'(issue_stall), 64'(1));
    @(posedge clk); #1;
    issue_en = 1'b0;
    check_eq("t3_pend", 64'(pend_mask), 64'(15'h0020));
    src_1 = 4'd5; src_2 = 4'd0; #1;
    check_eq("t3_hazard_s1", 64'(hazard), 64'(1));
    src_1 = 4'd15; #1;
    check_eq("t3_hazard_oob", 64'(hazard), 64'(0));
    src_2 = 4'd5; #1;
    check_eq("t3_hazard_s2", 64'(hazard), 64'(1));
    src_1 = 4'd5; src_2 = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_dest = 4'd5; req0_data = 32'(k + 32'h50);
      #1;
      check_eq($sformatf("t3_hazard_pre%0d", k), 64'(hazard), 64'(1));
      @(posedge clk); #1;
      check_eq($sformatf("t3_wb_dest%0d", k), 64'(wb_dest), 64'(5));
    end
    req0_valid = 1'b0;
    #1;
    check_eq("t3_hazard_clear", 64'(hazard), 64'(0));
    check_eq("t3_pend_clear", 64'(pend_mask), 64'(0));
    @(negedge clk); #1;
    check_eq("t3_rf5", 64'(rf_model[5]), 64'(32'h52));

    // 4: simultaneous reserve and retire on one register leaves the count unchanged
    @(negedge clk);
    issue_en = 1'b1; issue_dest = 4'd7;
    @(posedge clk); #1;
    issue_en = 1'b0;
    check_eq("t4_pend_a", 64'(pend_mask), 64'(15'h0080));
    @(negedge clk);
    issue_en = 1'b1; issue_dest = 4'd7;
    req0_valid = 1'b1; req0_dest = 4'd7; req0_data = 32'h77;
    #1;
    check_eq("t4_stall", 64'(issue_stall), 64'(0));
    @(posedge clk); #1;
    idle_inputs();
    check_eq("t4_pend_b", 64'(pend_mask), 64'(15'h0080));
    check_eq("t4_wb_dest", 64'(wb_dest), 64'(7));
    @(negedge clk);
    req0_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("t4_pend_c", 64'(pend_mask), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check_eq("t4_nounderflow", 64'(pend_mask), 64'(0));
    check_eq("t4_wb_en_zero_cnt", 64'(wb_en), 64'(1));

    // 5: out-of-range destination is consumed but never written
    @(negedge clk);
    req1_valid = 1'b1; req1_dest = 4'd15; req1_data = 32'hDEAD;
    #1;
    check_eq("t5_req1_ready", 64'(req1_ready), 64'(1));
    @(posedge clk); #1;
    req1_valid = 1'b0;
    check_eq("t5_wb_en", 64'(wb_en), 64'(0));
    check_eq("t5_err", 64'(err_bad_dest), 64'(1));
    @(negedge clk);
    issue_en = 1'b1; issue_dest = 4'd15;
    #1;
    check_eq("t5_issue_stall", 64'(issue_stall), 64'(0));
    @(posedge clk); #1;
    issue_en = 1'b0;
    check_eq("t5_pend", 64'(pend_mask), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_err_sticky", 64'(err_bad_dest), 64'(1));
    apply_reset();
    #1;
    check_eq("t5_err_rst", 64'(err_bad_dest), 64'(0));

    // 6: asynchronous reset mid-cycle with traffic in flight
    @(negedge clk);
    issue_en = 1'b1; issue_dest = 4'd2;
    req0_valid = 1'b1; req0_dest = 4'd1; req0_data = 32'h61;
    req1_valid = 1'b1; req1_dest = 4'd2; req1_data = 32'h62;
    @(posedge clk); #1;
    issue_en = 1'b0;
    check_eq("t6_wb_en_pre", 64'(wb_en), 64'(1));
    check_eq("t6_pend_pre", 64'(pend_mask), 64'(15'h0004));
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_wb_en_rst", 64'(wb_en), 64'(0));
    check_eq("t6_pend_rst", 64'(pend_mask), 64'(0));
    check_eq("t6_wb_dest_rst", 64'(wb_dest), 64'(0));
    check_eq("t6_req0_ready_rst", 64'(req0_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t6_req0_ready", 64'(req0_ready), 64'(1));
    check_eq("t6_req1_ready", 64'(req1_ready), 64'(0));
    @(posedge clk); #1;
    idle_inputs();
    check_eq("t6_wb_dest", 64'(wb_dest), 64'(1));
    check_eq("t6_wb_data", 64'(wb_data), 64'(32'h61));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
